// File: rtl/usr_shift_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : usr_shift_ctrl
//  Purpose  : Sequencing controller for a universal shift register (usr).
//             A one-cycle START launches one complete transfer:
//               transmit : CLEAR -> LOAD -> WIDTH x SHIFT -> CAPTURE -> DONE_S
//               receive  : CLEAR -> WIDTH x SHIFT -> CAPTURE -> DONE_S
//             The usr control pins are driven directly from registers.
//
//  Ports    : CLK                 system clock, rising edge
//             RST                 asynchronous reset, active low
//             START               transfer request (IDLE only)
//             MODE_RX             0 = transmit, 1 = receive (latched at START)
//             DIR                 shift direction (latched at START)
//             ABORT               synchronous abort back to IDLE
//             DATA_IN             transmit word (latched at START)
//             SERIAL_IN_EXT       external receive bit
//             USR_SERIAL_OUT      usr serial output
//             USR_PARALLEL_OUT    usr parallel output
//             USR_CLR             usr clear, active low
//             USR_PARALLEL_MODE   1 = usr parallel load, 0 = shift
//             USR_SI              usr serial input
//             USR_SR              usr shift-direction select
//             USR_PARALLEL_INPUT  usr parallel load data
//             BUSY                transfer in progress
//             DONE                one-cycle completion pulse
//             TX_BIT              current transmitted bit (= USR_SERIAL_OUT)
//             TX_VALID            TX_BIT valid this cycle
//             RX_DATA             last received word
//             RX_VALID            one-cycle pulse with DONE on receive
//
//  Revision : 1.0  initial release
// ============================================================================
module usr_shift_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             MODE_RX,
    input  logic             DIR,
    input  logic             ABORT,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic             SERIAL_IN_EXT,
    input  logic             USR_SERIAL_OUT,
    input  logic [WIDTH-1:0] USR_PARALLEL_OUT,
    output logic             USR_CLR,
    output logic             USR_PARALLEL_MODE,
    output logic             USR_SI,
    output logic             USR_SR,
    output logic [WIDTH-1:0] USR_PARALLEL_INPUT,
    output logic             BUSY,
    output logic             DONE,
    output logic             TX_BIT,
    output logic             TX_VALID,
    output logic [WIDTH-1:0] RX_DATA,
    output logic             RX_VALID
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_LOAD    = 3'd2,
        S_SHIFT   = 3'd3,
        S_CAPTURE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_cnt_zero = '0;
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;

    // Transfer attributes captured on the accepting edge.
    logic               r_mode_rx;
    logic               r_dir;
    logic [WIDTH-1:0]   r_data;

    logic               w_accept;
    logic               w_mode_eff;
    logic               w_dir_eff;

    // A START is taken only from IDLE and loses to a simultaneous ABORT.
    assign w_accept = (r_state == S_IDLE) && START && !ABORT;

    // The output registers are decoded from the next state, so on the
    // accepting edge the attributes must come straight from the inputs
    // rather than from the (not yet updated) attribute registers.
    assign w_mode_eff = w_accept ? MODE_RX : r_mode_rx;
    assign w_dir_eff  = w_accept ? DIR     : r_dir;

    // TX_BIT is the only unregistered output.
    assign TX_BIT = USR_SERIAL_OUT;

    // ------------------------------------------------------------------
    // Next-state and bit-counter logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;

        case (r_state)
            S_IDLE: begin
                w_cnt_next = c_cnt_zero;
                if (START) begin
                    w_state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_cnt_next   = c_cnt_zero;
                w_state_next = r_mode_rx ? S_SHIFT : S_LOAD;
            end
            S_LOAD: begin
                w_cnt_next   = c_cnt_zero;
                w_state_next = S_SHIFT;
            end
            S_SHIFT: begin
                // Counter runs 0..WIDTH-1, giving exactly WIDTH shift cycles.
                w_cnt_next = r_cnt + c_cnt_one;
                if (r_cnt == c_cnt_last) begin
                    w_cnt_next   = c_cnt_zero;
                    w_state_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                w_cnt_next   = c_cnt_zero;
                w_state_next = S_DONE;
            end
            S_DONE: begin
                // START here is deliberately ignored; no request is queued.
                w_cnt_next   = c_cnt_zero;
                w_state_next = S_IDLE;
            end
            default: begin
                w_cnt_next   = c_cnt_zero;
                w_state_next = S_IDLE;
            end
        endcase

        // ABORT overrides every transition, including a START from IDLE.
        if (ABORT) begin
            w_state_next = S_IDLE;
            w_cnt_next   = c_cnt_zero;
        end
    end

    // ------------------------------------------------------------------
    // State, counter and latched transfer attributes
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= S_IDLE;
            r_cnt     <= c_cnt_zero;
            r_mode_rx <= 1'b0;
            r_dir     <= 1'b0;
            r_data    <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_mode_rx <= MODE_RX;
                r_dir     <= DIR;
                r_data    <= DATA_IN;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs, decoded from the state being entered so that
    // each output is valid during the cycle its state is occupied.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            USR_CLR            <= 1'b1;
            USR_PARALLEL_MODE  <= 1'b0;
            USR_SI             <= 1'b0;
            USR_SR             <= 1'b0;
            USR_PARALLEL_INPUT <= '0;
            BUSY               <= 1'b0;
            DONE               <= 1'b0;
            TX_VALID           <= 1'b0;
            RX_DATA            <= '0;
            RX_VALID           <= 1'b0;
        end else begin
            USR_CLR            <= (w_state_next != S_CLEAR);
            USR_PARALLEL_MODE  <= (w_state_next == S_LOAD);
            USR_PARALLEL_INPUT <= (w_state_next == S_LOAD) ? r_data : '0;
            USR_SR             <= (w_state_next != S_IDLE) ? w_dir_eff : 1'b0;

            // The receive bit presented to the usr in a SHIFT cycle is the
            // SERIAL_IN_EXT value sampled on the edge that starts that cycle;
            // the usr shifts it in at the end of the cycle.
            USR_SI <= ((w_state_next == S_SHIFT) && w_mode_eff) ? SERIAL_IN_EXT : 1'b0;

            BUSY     <= (w_state_next == S_CLEAR)   || (w_state_next == S_LOAD) ||
                        (w_state_next == S_SHIFT)   || (w_state_next == S_CAPTURE);
            TX_VALID <= (w_state_next == S_SHIFT) && !w_mode_eff;
            DONE     <= (w_state_next == S_DONE);
            RX_VALID <= (w_state_next == S_DONE) && r_mode_rx;

            // Leaving CAPTURE normally: the usr word now holds all WIDTH
            // shifts. An ABORT in CAPTURE suppresses the update.
            if ((w_state_next == S_DONE) && r_mode_rx) begin
                RX_DATA <= USR_PARALLEL_OUT;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_usr_shift_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_usr_shift_ctrl
//  Purpose  : Self-checking bench for usr_shift_ctrl with a behavioural usr
//             and a transfer-timeline reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_usr_shift_ctrl;

    localparam int W = 4;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         START = 1'b0;
    logic         MODE_RX = 1'b0;
    logic         DIR = 1'b0;
    logic         ABORT = 1'b0;
    logic [W-1:0] DATA_IN = '0;
    logic         SERIAL_IN_EXT = 1'b0;
    logic         USR_SERIAL_OUT;
    logic [W-1:0] USR_PARALLEL_OUT;
    logic         USR_CLR;
    logic         USR_PARALLEL_MODE;
    logic         USR_SI;
    logic         USR_SR;
    logic [W-1:0] USR_PARALLEL_INPUT;
    logic         BUSY;
    logic         DONE;
    logic         TX_BIT;
    logic         TX_VALID;
    logic [W-1:0] RX_DATA;
    logic         RX_VALID;

    int n_vec = 0;
    int n_err = 0;

    usr_shift_ctrl #(.WIDTH(W)) dut (
        .CLK                (CLK),
        .RST                (RST),
        .START              (START),
        .MODE_RX            (MODE_RX),
        .DIR                (DIR),
        .ABORT              (ABORT),
        .DATA_IN            (DATA_IN),
        .SERIAL_IN_EXT      (SERIAL_IN_EXT),
        .USR_SERIAL_OUT     (USR_SERIAL_OUT),
        .USR_PARALLEL_OUT   (USR_PARALLEL_OUT),
        .USR_CLR            (USR_CLR),
        .USR_PARALLEL_MODE  (USR_PARALLEL_MODE),
        .USR_SI             (USR_SI),
        .USR_SR             (USR_SR),
        .USR_PARALLEL_INPUT (USR_PARALLEL_INPUT),
        .BUSY               (BUSY),
        .DONE               (DONE),
        .TX_BIT             (TX_BIT),
        .TX_VALID           (TX_VALID),
        .RX_DATA            (RX_DATA),
        .RX_VALID           (RX_VALID)
    );

    always #5 CLK = ~CLK;

    // ------------------------------------------------------------------
    // Behavioural usr: clear, parallel load, or shift every clock.
    // SR=1 shifts right (serial out = bit 0), SR=0 shifts left.
    // ------------------------------------------------------------------
    logic [W-1:0] usr_q = '0;
    always @(posedge CLK) begin
        if (!USR_CLR)               usr_q <= '0;
        else if (USR_PARALLEL_MODE) usr_q <= USR_PARALLEL_INPUT;
        else if (USR_SR)            usr_q <= {USR_SI, usr_q[W-1:1]};
        else                        usr_q <= {usr_q[W-2:0], USR_SI};
    end
    assign USR_PARALLEL_OUT = usr_q;
    assign USR_SERIAL_OUT   = USR_SR ? usr_q[0] : usr_q[W-1];

    // ------------------------------------------------------------------
    // Reference model: a transfer is a timeline of cycle offsets after the
    // accepting edge (offset 1 = clear). Receive word built arithmetically.
    // ------------------------------------------------------------------
    bit           m_act = 1'b0;
    int           m_ofs = 0;
    bit           m_rx = 1'b0;
    bit           m_dir = 1'b0;
    logic [W-1:0] m_data = '0;
    int           m_word = 0;
    int           m_si = 0;
    logic [W-1:0] m_rxd = '0;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_act = 1'b0; m_ofs = 0; m_rxd = '0; m_si = 0; m_word = 0;
        end else if (!m_act) begin
            if (START && !ABORT) begin
                m_act = 1'b1; m_ofs = 1; m_rx = MODE_RX; m_dir = DIR;
                m_data = DATA_IN; m_word = 0; m_si = 0;
            end
        end else if (ABORT) begin
            m_act = 1'b0; m_ofs = 0;
        end else if (m_ofs == (m_rx ? W + 3 : W + 4)) begin
            m_act = 1'b0; m_ofs = 0;
        end else begin
            m_ofs = m_ofs + 1;
            if (m_rx && m_ofs >= 2 && m_ofs < 2 + W) begin
                m_si = SERIAL_IN_EXT ? 1 : 0;
                if (m_dir) m_word = m_word / 2 + m_si * (1 << (W - 1));
                else       m_word = (m_word * 2) % (1 << W) + m_si;
            end
            if (m_rx && m_ofs == W + 3) m_rxd = W'(m_word);
        end
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkw(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Per-cycle comparison against the model, away from the active edge.
    // ------------------------------------------------------------------
    bit e_clear, e_load, e_shift, e_done;
    int first, tot, k;
    always @(negedge CLK) begin
        if (!RST) begin
            chk1("rst_busy", BUSY, 1'b0);
            chk1("rst_done", DONE, 1'b0);
            chk1("rst_clr", USR_CLR, 1'b1);
            chk1("rst_pmode", USR_PARALLEL_MODE, 1'b0);
            chk1("rst_si", USR_SI, 1'b0);
            chk1("rst_sr", USR_SR, 1'b0);
            chkw("rst_pin", USR_PARALLEL_INPUT, '0);
            chk1("rst_txv", TX_VALID, 1'b0);
            chkw("rst_rxd", RX_DATA, '0);
            chk1("rst_rxv", RX_VALID, 1'b0);
        end else begin
            tot     = m_rx ? W + 3 : W + 4;
            first   = m_rx ? 2 : 3;
            e_clear = m_act && m_ofs == 1;
            e_load  = m_act && !m_rx && m_ofs == 2;
            e_shift = m_act && m_ofs >= first && m_ofs < first + W;
            e_done  = m_act && m_ofs == tot;
            chk1("busy", BUSY, m_act && !e_done);
            chk1("done", DONE, e_done);
            chk1("clr_n", USR_CLR, !e_clear);
            chk1("pmode", USR_PARALLEL_MODE, e_load);
            chk1("tx_valid", TX_VALID, e_shift && !m_rx);
            chk1("rx_valid", RX_VALID, e_done && m_rx);
            chkw("rx_data", RX_DATA, m_rxd);
            if (e_load) chkw("pin", USR_PARALLEL_INPUT, m_data);
            if (e_shift) begin
                chk1("sr", USR_SR, m_dir);
                chk1("si", USR_SI, m_rx && (m_si != 0));
                if (!m_rx) begin
                    k = m_ofs - first;
                    chk1("tx_bit", TX_BIT, m_dir ? m_data[k] : m_data[W-1-k]);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed-scenario observer
    // ------------------------------------------------------------------
    bit           hold_start = 1'b0;
    bit           use_si = 1'b0;
    int           abort_at = -1;
    logic [W-1:0] si_seq = '0;
    int           o_busy, o_clr, o_clr2, o_pm, o_txv, o_done1, o_done_n, o_rxv, o_rxv_cyc;
    logic [W-1:0] o_pin, o_tx, o_rxd_at_done;

    task automatic nxt();
        @(negedge CLK);
        #1;
    endtask

    task automatic observe(input int n);
        o_busy = 0; o_clr = 0; o_clr2 = -1; o_pm = 0; o_txv = 0; o_done1 = -1;
        o_done_n = 0; o_rxv = 0; o_rxv_cyc = -1; o_pin = '0; o_tx = '0; o_rxd_at_done = '0;
        for (int c = 1; c <= n; c++) begin
            @(negedge CLK);
            if (BUSY) o_busy++;
            if (!USR_CLR) begin o_clr++; if (o_clr == 2) o_clr2 = c; end
            if (USR_PARALLEL_MODE) begin o_pm++; o_pin = USR_PARALLEL_INPUT; end
            if (TX_VALID) begin if (o_txv < W) o_tx[o_txv] = TX_BIT; o_txv++; end
            if (DONE) begin
                o_done_n++;
                if (o_done1 < 0) begin o_done1 = c; o_rxd_at_done = RX_DATA; end
            end
            if (RX_VALID) begin o_rxv++; o_rxv_cyc = c; end
            #1;
            START = hold_start;
            ABORT = (c == abort_at);
            if (use_si && c <= W) SERIAL_IN_EXT = si_seq[c-1];
            else                  SERIAL_IN_EXT = 1'($urandom_range(0, 1));
            if (!hold_start) begin
                MODE_RX = 1'($urandom_range(0, 1));
                DIR     = 1'($urandom_range(0, 1));
                DATA_IN = W'($urandom);
            end
        end
    endtask

    initial begin
        #2 RST = 1'b0;
        @(negedge CLK);
        #1 RST = 1'b1;

        // Transmit 1010, right shift.
        nxt(); START = 1'b1; MODE_RX = 1'b0; DIR = 1'b1; DATA_IN = 4'b1010;
        observe(10);
        chk1("tx_busy7", o_busy == 7, 1'b1);
        chk1("tx_clr1", o_clr == 1, 1'b1);
        chk1("tx_pm1", o_pm == 1, 1'b1);
        chkw("tx_pin", o_pin, 4'b1010);
        chk1("tx_txv4", o_txv == 4, 1'b1);
        chkw("tx_bits", o_tx, 4'b1010);
        chk1("tx_done_c8", o_done1 == 8, 1'b1);
        chk1("tx_no_rxv", o_rxv == 0, 1'b1);

        // Receive 1,1,0,1 right shift -> 1011.
        nxt(); START = 1'b1; MODE_RX = 1'b1; DIR = 1'b1;
        use_si = 1'b1; si_seq = 4'b1011;
        observe(9);
        use_si = 1'b0;
        chk1("rx_done_c7", o_done1 == 7, 1'b1);
        chk1("rx_rxv_c7", o_rxv_cyc == 7, 1'b1);
        chkw("rx_word", o_rxd_at_done, 4'b1011);

        // START held high: one IDLE cycle between DONE and next CLEAR.
        nxt(); START = 1'b1; MODE_RX = 1'b0; DIR = 1'b0; DATA_IN = 4'b0110;
        hold_start = 1'b1;
        observe(20);
        hold_start = 1'b0;
        chk1("b2b_done_c8", o_done1 == 8, 1'b1);
        chk1("b2b_gap", o_clr2 == o_done1 + 2, 1'b1);
        chk1("b2b_two_done", o_done_n == 2, 1'b1);
        observe(12);

        // ABORT in the 2nd SHIFT cycle of a receive.
        nxt(); START = 1'b1; MODE_RX = 1'b1; DIR = 1'b0;
        abort_at = 3;
        observe(12);
        abort_at = -1;
        chk1("ab_busy3", o_busy == 3, 1'b1);
        chk1("ab_no_done", o_done_n == 0, 1'b1);
        chk1("ab_no_rxv", o_rxv == 0, 1'b1);
        chkw("ab_rxd_kept", RX_DATA, 4'b1011);

        // Asynchronous reset mid-SHIFT, then a fresh left-shift transmit.
        nxt(); START = 1'b1; MODE_RX = 1'b0; DIR = 1'b1; DATA_IN = 4'b0101;
        observe(4);
        @(posedge CLK);
        #2 RST = 1'b0;
        #1;
        chk1("ar_busy", BUSY, 1'b0);
        chk1("ar_clr", USR_CLR, 1'b1);
        chk1("ar_txv", TX_VALID, 1'b0);
        chkw("ar_rxd", RX_DATA, '0);
        @(negedge CLK);
        #1 RST = 1'b1;
        nxt(); START = 1'b1; MODE_RX = 1'b0; DIR = 1'b0; DATA_IN = 4'b1100;
        observe(10);
        chk1("ar_done_c8", o_done1 == 8, 1'b1);
        chkw("ar_tx_bits", o_tx, 4'b0011);

        // START and ABORT together in IDLE.
        nxt(); START = 1'b1; ABORT = 1'b1;
        nxt(); START = 1'b0; ABORT = 1'b0;
        chk1("sa_busy", BUSY, 1'b0);
        chk1("sa_clr", USR_CLR, 1'b1);

        // Randomized traffic with occasional aborts and async resets.
        for (int i = 0; i < 400; i++) begin
            nxt();
            START         = ($urandom_range(0, 3) == 0);
            MODE_RX       = 1'($urandom_range(0, 1));
            DIR           = 1'($urandom_range(0, 1));
            DATA_IN       = W'($urandom);
            SERIAL_IN_EXT = 1'($urandom_range(0, 1));
            ABORT         = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 149) == 0) begin
                @(posedge CLK);
                #3 RST = 1'b0;
                @(negedge CLK);
                #1 RST = 1'b1;
            end
        end
        START = 1'b0;
        ABORT = 1'b0;
        repeat (3) nxt();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
